pipe_flow_ctrl: RTL
===================

Name: pipe_flow_ctrl

Overview:
- Parametrised pipeline flow/hazard controller; successor to the fixed 5-stage flow control.
- Drives one 2-bit condition code per stage (IF, ID, then WSTAGES write-capable stages EX, MEM, WB, ...).
- Arbitrates RAW hazards, multi-cycle mult/div stalls and overflow cancellation.
- Keeps a bounded-latency watchdog and a stall-cycle counter.

Parameters:
- ADDR_W, 7: register-space address width (GPR plus HI/LO/CP0 class bits); address 0 = "no dependency".
- WSTAGES, 3: in-flight write stages after ID; total stages NST = WSTAGES+2.
- MD_MAX, 40: max mult/div busy cycles before timeout; minimum 2.
- CNT_W, 16: stall counter width.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low.
- raddr1, input, ADDR_W: ID-stage source address 1.
- raddr2, input, ADDR_W: ID-stage source address 2.
- waddr, input, WSTAGES*ADDR_W: write address per stage; slice k=0 is EX, k=WSTAGES-1 is oldest.
- ex_is_load, input, 1: EX instruction is a load (used only with FORWARDING_EN).
- md_start, input, 1: one-cycle pulse, multi-cycle op entered EX.
- md_done, input, 1: multi-cycle result ready.
- ovf, input, 1: arithmetic overflow in EX.
- cond, output, NST*2: per-stage code; slice s=0 is IF. 00 RUN, 01 STALL (hold), 10 FLUSH (bubble/clear). 11 is never driven.
- md_busy, output, 1: FSM in MD_BUSY.
- md_timeout, output, 1: sticky watchdog flag.
- stall_cnt, output, CNT_W: saturating count of IF-stall cycles.

Behaviour:
- FSM states: IDLE, MD_BUSY. State, md_cnt, md_timeout and stall_cnt are registered; cond is combinational from state and inputs.
- Reset low:
  - state=IDLE, md_cnt=0, md_timeout=0, stall_cnt=0.
  - All cond slices = FLUSH.
  - Reset mid-MD_BUSY abandons the operation immediately.
- Priority per cycle: ovf > MD_BUSY/md_start > RAW > run.
- ovf=1 (any state):
  - cond[IF], cond[ID], cond[EX] = FLUSH; remaining stages RUN.
  - Next state IDLE, md_cnt cleared.
  - Does not count as a stall.
- md_start in IDLE (ovf=0):
  - Same cycle: IF, ID, EX = STALL; stage 3 (MEM) = FLUSH; later stages RUN.
  - Next state MD_BUSY, md_cnt=0.
- MD_BUSY:
  - Same cond pattern as md_start.
  - md_cnt increments each cycle.
  - md_done=1: that cycle's cond is all RUN except MEM=FLUSH, so the result advances on the edge; next state IDLE.
  - md_cnt reaching MD_MAX-1 without md_done: set md_timeout, next state IDLE.
  - md_start while already in MD_BUSY is ignored.
- RAW hazard (IDLE, no ovf, no md_start):
  - Hazard when raddrN != 0 and raddrN == waddr[k] for any k in 0..WSTAGES-1, and waddr[k] != 0.
  - Response: IF, ID = STALL; EX = FLUSH; rest RUN.
  - Held until the match clears; no timeout.
- stall_cnt increments on each edge where cond[IF]==STALL; saturates at all-ones and does not wrap.
- md_busy = (state==MD_BUSY).
- md_timeout is cleared only by reset.

Optional Feature:
- FORWARDING_EN defined:
  - RAW stalls only on load-use: match against waddr[0] with ex_is_load=1.
  - Adds outputs fwd_sel1 and fwd_sel2, each clog2(WSTAGES+1) wide: 0 = register file, k+1 = forward from stage k, nearest stage wins.
  - fwd_sel is 0 while reset is low or when raddr==0.
- FORWARDING_EN undefined: ports absent; ex_is_load ignored; any match stalls as above.

Test Plan:
- Reset low with random inputs -> cond all 10; stall_cnt=0. Release -> with no hazards, cond all 00.
- raddr1=5, waddr[1]=5 for 2 cycles -> IF/ID=01 and EX=10 for 2 cycles, then all 00; stall_cnt=2. With FORWARDING_EN: no stall, fwd_sel1=2.
- md_start pulse, md_done after 10 cycles -> IF/ID/EX=01 and MEM=10 for 10 cycles; md_busy high for 10 cycles; done cycle all 00 except MEM=10; stall_cnt=10.
- md_start, md_done never asserted, MD_MAX=40 -> md_timeout=1 after 40 stall cycles, FSM IDLE, flag sticky until reset.
- ovf=1 concurrent with a RAW match and a pending MD_BUSY -> IF/ID/EX=10 that cycle; next cycle IDLE, no stall counted.
- Force 2^CNT_W+5 hazard cycles -> stall_cnt holds at 0xFFFF (CNT_W=16).

Source files
------------

// File: rtl/pipe_flow_ctrl.sv
// Parametrised pipeline flow/hazard controller: per-stage RUN/STALL/FLUSH codes, mult/div watchdog, stall counter.
// Build macro FORWARDING_EN: stall only on load-use and expose fwd_sel1/fwd_sel2.
module pipe_flow_ctrl #(
  parameter  int ADDR_W  = 7,
  parameter  int WSTAGES = 3,
  parameter  int MD_MAX  = 40,
  parameter  int CNT_W   = 16,
  localparam int NST     = WSTAGES + 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           raddr1,
  input  logic [ADDR_W-1:0]           raddr2,
  input  logic [WSTAGES*ADDR_W-1:0]   waddr,
  input  logic                        ex_is_load,
  input  logic                        md_start,
  input  logic                        md_done,
  input  logic                        ovf,
  output logic [NST*2-1:0]            cond,
  output logic                        md_busy,
  output logic                        md_timeout,
  output logic [CNT_W-1:0]            stall_cnt
`ifdef FORWARDING_EN
  ,
  output logic [$clog2(WSTAGES+1)-1:0] fwd_sel1,
  output logic [$clog2(WSTAGES+1)-1:0] fwd_sel2
`endif
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MD_BUSY = 1'b1} state_e;

  localparam logic [1:0] C_RUN   = 2'b00;
  localparam logic [1:0] C_STALL = 2'b01;
  localparam logic [1:0] C_FLUSH = 2'b10;
  localparam int         MDC_W   = $clog2(MD_MAX);

  state_e              state_q;
  logic [MDC_W-1:0]    md_cnt_q;
  logic                md_timeout_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic [CNT_W-1:0]    stall_cnt_d;
  logic                haz_s;
  logic [NST-1:0][1:0] cond_s;

  // Address 0 means "no dependency", so a hit requires a non-zero source.
  function automatic logic addr_hit(input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] w);
    return (r != {ADDR_W{1'b0}}) && (r == w);
  endfunction

  // RAW hazard detection against the in-flight write stages
  always_comb begin
    haz_s = 1'b0;
`ifdef FORWARDING_EN
    haz_s = ex_is_load && (addr_hit(raddr1, waddr[ADDR_W-1:0]) || addr_hit(raddr2, waddr[ADDR_W-1:0]));
`else
    for (int k = 0; k < WSTAGES; k++) begin
      haz_s = haz_s | addr_hit(raddr1, waddr[k*ADDR_W +: ADDR_W])
                    | addr_hit(raddr2, waddr[k*ADDR_W +: ADDR_W]);
    end
`endif
  end

`ifdef FORWARDING_EN
  localparam int FWW = $clog2(WSTAGES + 1);
  logic [FWW-1:0] sel1_s;
  logic [FWW-1:0] sel2_s;

  // Forward select: scan oldest to youngest so the nearest matching stage wins
  always_comb begin
    sel1_s = {FWW{1'b0}};
    sel2_s = {FWW{1'b0}};
    for (int k = WSTAGES - 1; k >= 0; k--) begin
      sel1_s = addr_hit(raddr1, waddr[k*ADDR_W +: ADDR_W]) ? FWW'(k + 1) : sel1_s;
      sel2_s = addr_hit(raddr2, waddr[k*ADDR_W +: ADDR_W]) ? FWW'(k + 1) : sel2_s;
    end
  end

  assign fwd_sel1 = reset ? sel1_s : {FWW{1'b0}};
  assign fwd_sel2 = reset ? sel2_s : {FWW{1'b0}};
`else
  logic unused_ex_is_load_s;
  assign unused_ex_is_load_s = ex_is_load;
`endif

  // Per-stage condition codes, priority ovf > mult/div > RAW > run
  always_comb begin
    cond_s = {NST{C_RUN}};
    if (!reset) begin
      cond_s = {NST{C_FLUSH}};
    end else if (ovf) begin
      cond_s[0] = C_FLUSH;
      cond_s[1] = C_FLUSH;
      cond_s[2] = C_FLUSH;
    end else if ((state_q == S_MD_BUSY) && md_done) begin
      cond_s[3] = C_FLUSH;
    end else if ((state_q == S_MD_BUSY) || md_start) begin
      cond_s[0] = C_STALL;
      cond_s[1] = C_STALL;
      cond_s[2] = C_STALL;
      cond_s[3] = C_FLUSH;
    end else if (haz_s) begin
      cond_s[0] = C_STALL;
      cond_s[1] = C_STALL;
      cond_s[2] = C_FLUSH;
    end else begin
      cond_s = {NST{C_RUN}};
    end
  end

  // Saturating IF-stall count
  always_comb begin
    if ((cond_s[0] == C_STALL) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Mult/div FSM with watchdog; the timeout fires on the edge md_cnt would reach MD_MAX-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      md_cnt_q     <= {MDC_W{1'b0}};
      md_timeout_q <= 1'b0;
      stall_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (ovf) begin
        state_q  <= S_IDLE;
        md_cnt_q <= {MDC_W{1'b0}};
      end else begin
        case (state_q)
          S_IDLE: begin
            if (md_start) begin
              state_q  <= S_MD_BUSY;
              md_cnt_q <= {MDC_W{1'b0}};
            end else begin
              state_q  <= S_IDLE;
            end
          end
          S_MD_BUSY: begin
            if (md_done) begin
              state_q  <= S_IDLE;
              md_cnt_q <= {MDC_W{1'b0}};
            end else if (md_cnt_q == MDC_W'(MD_MAX - 2)) begin
              state_q      <= S_IDLE;
              md_cnt_q     <= {MDC_W{1'b0}};
              md_timeout_q <= 1'b1;
            end else begin
              md_cnt_q <= md_cnt_q + {{(MDC_W-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            state_q  <= S_IDLE;
            md_cnt_q <= {MDC_W{1'b0}};
          end
        endcase
      end
    end
  end

  assign cond       = cond_s;
  assign md_busy    = (state_q == S_MD_BUSY);
  assign md_timeout = md_timeout_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
